joy_dir_arb: RTL and testbench
==============================

JOY_DIR_ARB -- requirements
Module: joy_dir_arb

Interface
REQ-001 SHALL have parameter PLAYERS, default 2, number of independent joystick lanes (1-4).
REQ-002 SHALL have parameter DEB_W, default 4, width of per-bit debounce counter.
REQ-003 SHALL have parameter DEB_CNT, default 0, consecutive ce samples required to accept a change; 0 = debounce bypass.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on posedge clk.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port ce, input, 1, debounce sample enable.
REQ-007 SHALL have port mode, input, 2*PLAYERS, per-lane mode; lane p at [2p+1:2p].
REQ-008 SHALL have port joy_in, input, 4*PLAYERS, raw directions; lane p nibble [4p+3:4p] = {up,down,left,right}.
REQ-009 SHALL have port joy_out, output, 4*PLAYERS, filtered directions, same bit order, registered.

Function
REQ-010 SHALL register joy_in into stage s1 every clk.
REQ-011 SHALL, with DEB_CNT=0, use deb = s1 directly.
REQ-012 SHALL, with DEB_CNT>0, flip a deb bit only after s1 differs from it on DEB_CNT consecutive ce=1 cycles; counter clears when s1 equals deb; counter saturates, never wraps.
REQ-013 SHALL derive new = deb & ~deb_d, where deb_d is deb delayed one clk.
REQ-014 SHALL, in mode 00 (8-way), output deb with SOCD cleaning: up+down both set -> both 0; left+right both set -> both 0.
REQ-015 SHALL, in mode 01 (4-way last-pressed), set mask to the one-hot of any new bit; simultaneous new bits resolve up > down > left > right; output deb & mask.
REQ-016 SHALL, in mode 10 (4-way first-held), load mask from new only when mask = 4'hF; a held direction keeps ownership until released.
REQ-017 SHALL, in mode 11 (2-way horizontal), force up/down outputs to 0 and apply mode-01 rules to left/right only.
REQ-018 SHALL, in modes 01/10/11, reset mask to 4'hF when (deb & mask) = 0; this release rule overrides new-press loading in the same cycle.
REQ-019 SHALL, when a lane's mode changes, set its mask to 4'hF on the next clk and ignore new in that cycle.
REQ-020 SHALL register joy_out; latency joy_in -> joy_out = 2 clk with DEB_CNT=0.
REQ-021 SHALL keep lanes fully independent; no cross-lane interaction.
REQ-022 SHALL treat all-ones mask as "no owner"; with mask=4'hF, output in modes 01/10 equals deb.

Reset
REQ-023 SHALL, on reset assertion, immediately clear s1, deb, deb_d, debounce counters and joy_out to 0 and set every mask to 4'hF.
REQ-024 SHALL, on reset released mid-press, treat already-held inputs as new once deb rises.

Structure
REQ-025 SHALL place mode encodings (MODE_8WAY=00, MODE_4LAST=01, MODE_4FIRST=10, MODE_2H=11) and direction bit indices (UP=3, DOWN=2, LEFT=1, RIGHT=0) in shared package joy_arb_pkg.
REQ-026 SHALL implement one lane as sub-module joy_arb_lane, instantiated PLAYERS times by generate.

Verification
REQ-027 Lane 0 mode 01, DEB_CNT=0: right held, then up added -> joy_out=4'b1000 two clk after up; release up -> 4'b0001 (mask reset to F, right still held) two clk later.
REQ-028 Lane 0 mode 10: left held, then down added -> joy_out stays 4'b0010; release left -> 4'b0100.
REQ-029 Mode 00: joy_in=4'b1111 -> joy_out=4'b0000; joy_in=4'b1010 -> 4'b1010.
REQ-030 DEB_CNT=3, ce every 4th clk: 2-sample glitch on up -> no output change; 3-sample press -> up asserted 2 clk after third ce.
REQ-031 Mode 11: joy_in=4'b1001 -> joy_out=4'b0001; add left -> 4'b0010; assert reset mid-press -> joy_out=0 without waiting for a clk edge.
REQ-032 PLAYERS=2: lane 0 mode 01, lane 1 mode 00 with identical stimulus -> lane outputs differ per REQ-014/015; mode change on lane 1 leaves lane 0 mask untouched.

Source files
------------

// File: rtl/joy_arb_pkg.sv
// joy_arb_pkg: shared mode encodings, direction bit indices and priority helper
package joy_arb_pkg;
    localparam logic [1:0] MODE_8WAY   = 2'b00;
    localparam logic [1:0] MODE_4LAST  = 2'b01;
    localparam logic [1:0] MODE_4FIRST = 2'b10;
    localparam logic [1:0] MODE_2H     = 2'b11;
    localparam int UP    = 3;
    localparam int DOWN  = 2;
    localparam int LEFT  = 1;
    localparam int RIGHT = 0;
    localparam logic [3:0] NO_OWNER = 4'hF;
    function automatic logic [3:0] prio_1h(input logic [3:0] v);
        return v[UP] ? 4'b1000 : v[DOWN] ? 4'b0100 : v[LEFT] ? 4'b0010 : 4'b0001;
    endfunction
endpackage

// File: rtl/joy_arb_lane.sv
// joy_arb_lane: one joystick lane -- input stage, debounce, direction arbitration
// ports: clk, reset (async, active-high), ce (debounce sample enable),
//        mode[1:0], joy_in[3:0] {up,down,left,right}, joy_out[3:0] registered
module joy_arb_lane
    import joy_arb_pkg::*;
#(
    parameter int DEB_W   = 4,
    parameter int DEB_CNT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [1:0] mode,
    input  logic [3:0] joy_in,
    output logic [3:0] joy_out
);
    logic [3:0] s1, deb, deb_q, deb_d, rise, mask, mask_nxt, pick, out_nxt;
    logic [1:0] mode_q;
    logic [DEB_W-1:0] cnt [4];
    logic load;
    // a bit flips only after DEB_CNT consecutive ce samples disagree with it;
    // the counter clears on agreement or on the flip itself and never wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_q <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s1[i] == deb_q[i]) cnt[i] <= '0;
                else if (ce) begin
                    if (int'(cnt[i]) >= DEB_CNT - 1) begin
                        deb_q[i] <= s1[i];
                        cnt[i]   <= '0;
                    end else if (cnt[i] != '1) cnt[i] <= cnt[i] + DEB_W'(1);
                end
            end
        end
    end
    assign deb  = (DEB_CNT == 0) ? s1 : deb_q;
    assign rise = deb & ~deb_d;
    // output uses the next mask so a newly granted press shows with the same latency as deb
    always_comb begin
        pick = (mode == MODE_2H) ? prio_1h(rise & 4'b0011) : prio_1h(rise);
        load = (mode == MODE_4LAST)  ? |rise :
               (mode == MODE_2H)     ? |rise[1:0] :
               (mode == MODE_4FIRST) ? (mask == NO_OWNER) && |rise : 1'b0;
        mask_nxt = (mode != mode_q || mode == MODE_8WAY || (deb & mask) == 4'h0) ? NO_OWNER :
                   load ? pick : mask;
        out_nxt = (mode == MODE_8WAY) ?
                  {deb[UP] & ~deb[DOWN], deb[DOWN] & ~deb[UP], deb[LEFT] & ~deb[RIGHT], deb[RIGHT] & ~deb[LEFT]} :
                  deb & mask_nxt & ((mode == MODE_2H) ? 4'b0011 : 4'hF);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1      <= '0;
            deb_d   <= '0;
            mask    <= NO_OWNER;
            mode_q  <= MODE_8WAY;
            joy_out <= '0;
        end else begin
            s1      <= joy_in;
            deb_d   <= deb;
            mask    <= mask_nxt;
            mode_q  <= mode;
            joy_out <= out_nxt;
        end
    end
endmodule

// File: rtl/joy_dir_arb.sv
// joy_dir_arb: PLAYERS independent joystick lanes with debounce and direction arbitration
// ports: clk, reset (async, active-high), ce (debounce sample enable),
//        mode[2*PLAYERS-1:0] (2 bits per lane), joy_in/joy_out[4*PLAYERS-1:0] (nibble per lane)
module joy_dir_arb #(
    parameter int PLAYERS = 2,
    parameter int DEB_W   = 4,
    parameter int DEB_CNT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic [2*PLAYERS-1:0]   mode,
    input  logic [4*PLAYERS-1:0]   joy_in,
    output logic [4*PLAYERS-1:0]   joy_out
);
    for (genvar p = 0; p < PLAYERS; p++) begin : g_lane
        joy_arb_lane #(.DEB_W(DEB_W), .DEB_CNT(DEB_CNT)) u_lane (
            .clk(clk),
            .reset(reset),
            .ce(ce),
            .mode(mode[2*p +: 2]),
            .joy_in(joy_in[4*p +: 4]),
            .joy_out(joy_out[4*p +: 4])
        );
    end
endmodule

// File: tb/tb_joy_dir_arb.sv
// tb_joy_dir_arb: directed checks of arbitration modes, SOCD, debounce and reset
module tb_joy_dir_arb;
    logic       clk = 1'b0;
    logic       reset, ce;
    logic [3:0] mode0;
    logic [7:0] joy0, out0;
    logic [1:0] mode1;
    logic [3:0] joy1, out1;
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    joy_dir_arb #(.PLAYERS(2), .DEB_W(4), .DEB_CNT(0)) dut0 (
        .clk(clk), .reset(reset), .ce(ce), .mode(mode0), .joy_in(joy0), .joy_out(out0)
    );
    joy_dir_arb #(.PLAYERS(1), .DEB_W(4), .DEB_CNT(3)) dut1 (
        .clk(clk), .reset(reset), .ce(ce), .mode(mode1), .joy_in(joy1), .joy_out(out1)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait2();
        repeat (2) @(negedge clk);
    endtask

    task automatic ce_pulse();
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0;
        mode0 = 4'b00_01; joy0 = 8'h00;
        mode1 = 2'b00;    joy1 = 4'h0;
        wait2();
        check("reset_out0", out0, 8'h00);
        check("reset_out1", {4'h0, out1}, 8'h00);
        reset = 1'b0;
        @(negedge clk);
        // lane0 4-way last-pressed, lane1 8-way, identical stimulus
        joy0 = 8'h11; wait2(); check("right_held", out0, 8'h11);
        joy0 = 8'h99; wait2(); check("up_added", out0, 8'h98);
        mode0 = 4'b01_01; wait2(); check("l1_mode_chg", out0, 8'h98);
        joy0 = 8'h11; wait2(); check("up_release", out0, 8'h11);
        joy0 = 8'h00; wait2(); check("all_release", out0, 8'h00);
        // lane0 4-way first-held
        mode0 = 4'b00_10; wait2();
        joy0 = 8'h02; wait2(); check("first_left", out0, 8'h02);
        joy0 = 8'h06; wait2(); check("first_keep", out0, 8'h02);
        joy0 = 8'h04; wait2(); check("first_rel", out0, 8'h04);
        joy0 = 8'h00; wait2();
        // lane0 8-way SOCD
        mode0 = 4'b00_00; wait2();
        joy0 = 8'h0F; wait2(); check("socd_all", out0, 8'h00);
        joy0 = 8'h0A; wait2(); check("socd_ul", out0, 8'h0A);
        joy0 = 8'h0C; wait2(); check("socd_ud", out0, 8'h00);
        joy0 = 8'h07; wait2(); check("socd_dlr", out0, 8'h04);
        joy0 = 8'h00; wait2();
        // lane0 2-way horizontal, then async reset mid-press
        mode0 = 4'b00_11; wait2();
        joy0 = 8'h09; wait2(); check("h2_right", out0, 8'h01);
        joy0 = 8'h0B; wait2(); check("h2_left", out0, 8'h02);
        #1 reset = 1'b1;
        #1 check("async_rst", out0, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        wait2(); check("post_rst_new", out0, 8'h02);
        // debounce, DEB_CNT=3 with ce every 4th clk
        joy1 = 4'h8; @(negedge clk);
        ce_pulse(); ce_pulse();
        check("glitch_hold", {4'h0, out1}, 8'h00);
        joy1 = 4'h0; @(negedge clk);
        ce_pulse(); ce_pulse(); ce_pulse();
        check("glitch_after", {4'h0, out1}, 8'h00);
        joy1 = 4'h8; @(negedge clk);
        ce_pulse(); ce_pulse();
        check("deb_2of3", {4'h0, out1}, 8'h00);
        ce = 1'b1; @(negedge clk);
        ce = 1'b0; wait2();
        check("deb_3of3", {4'h0, out1}, 8'h08);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
